// File: rtl/window3x3_streamer_pkg.sv
// Shared types and helpers for the 3x3 window streamer
// and the Sobel stage that consumes its window bus.
package window3x3_streamer_pkg;

    localparam int PIX_W_DEF = 8;

    typedef logic [PIX_W_DEF-1:0] pix_t;
    typedef pix_t win_t [3][3];

    // Counter width for a 0..n-1 range, never below one bit.
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/window3x3_streamer_line_buffer.sv
// Line memory with asynchronous read, so the read sees the old
// word at the address being written on the same edge.
module line_buffer
    import window3x3_streamer_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int W     = 16,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/window3x3_streamer.sv
// Raster pixel stream to 3x3 neighbourhood stream with
// valid/ready on both sides and a single output register stage.
module window3x3_streamer
    import window3x3_streamer_pkg::*;
#(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256,
    parameter int PIX_W      = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] mat00,
    output logic [PIX_W-1:0] mat01,
    output logic [PIX_W-1:0] mat02,
    output logic [PIX_W-1:0] mat10,
    output logic [PIX_W-1:0] mat11,
    output logic [PIX_W-1:0] mat12,
    output logic [PIX_W-1:0] mat20,
    output logic [PIX_W-1:0] mat21,
    output logic [PIX_W-1:0] mat22,
    output logic             frame_done
);

    localparam int CW = cnt_w(IMG_WIDTH);
    localparam int RW = cnt_w(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0] col_q, col_d, col_cur;
    logic [RW-1:0] row_q, row_d, row_cur;

    // Index 0 is the oldest column, index 2 the newest.
    logic [2:0][PIX_W-1:0] top_q, mid_q, bot_q;

    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             sof, accept, emit, last_px;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign sof      = in_valid && in_sof;

    assign col_cur = sof ? '0 : col_q;
    assign row_cur = sof ? '0 : row_q;

    assign emit    = accept && (row_cur >= ROW_TWO)
                            && (col_cur >= COL_TWO);
    assign last_px = (row_cur == ROW_LAST)
                  && (col_cur == COL_LAST);

    // One memory holds both lines: upper half is row-2, lower row-1.
    line_buffer #(
        .DEPTH (IMG_WIDTH),
        .W     (2 * PIX_W),
        .AW    (CW)
    ) u_lb (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (col_cur),
        .wdata_i ({lb1_rd, in_pixel}),
        .rdata_o ({lb0_rd, lb1_rd})
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_cur == COL_LAST) begin
                col_d = '0;
                row_d = (row_cur == ROW_LAST) ? '0
                                              : row_cur + 1'b1;
            end else begin
                col_d = col_cur + 1'b1;
                row_d = row_cur;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        if (emit) begin
            valid_d = 1'b1;
            done_d  = last_px;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // The shift registers double as the output window: they only
    // move on an accept, which cannot happen while a window stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_q <= '0;
            mid_q <= '0;
            bot_q <= '0;
        end else if (accept) begin
            top_q <= {lb0_rd,   top_q[2], top_q[1]};
            mid_q <= {lb1_rd,   mid_q[2], mid_q[1]};
            bot_q <= {in_pixel, bot_q[2], bot_q[1]};
        end
    end

    assign out_valid  = valid_q;
    assign frame_done = done_q;

    assign mat00 = top_q[0];
    assign mat01 = top_q[1];
    assign mat02 = top_q[2];
    assign mat10 = mid_q[0];
    assign mat11 = mid_q[1];
    assign mat12 = mid_q[2];
    assign mat20 = bot_q[0];
    assign mat21 = bot_q[1];
    assign mat22 = bot_q[2];

endmodule
